// File: rtl/nim_input_bank.sv
// nim_input_bank: multi-channel NIM front-end conditioning bank.
// Per channel: polarity select, masked pattern match on an input history,
// rising-edge trigger with holdoff, pulse stretch and a programmable delay
// line. Also provides saturating per-channel trigger/holdoff counters and a
// masked N-fold coincidence output.
// Optional feature macro: NIM_GATE_EN (adds gate_in and gated_cnt).
module nim_input_bank #(
   parameter int NCH     = 4,
   parameter int PAT_W   = 8,
   parameter int DELAY_W = 7,
   parameter int STR_W   = 8,
   parameter int CNT_W   = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NCH-1:0]         trig_in,
   input  logic [NCH-1:0]         invert,
   input  logic [NCH*PAT_W-1:0]   mask,
   input  logic [NCH*PAT_W-1:0]   trig_pattern,
   input  logic [NCH*STR_W-1:0]   stretch,
   input  logic [NCH*STR_W-1:0]   holdoff,
   input  logic [NCH*DELAY_W-1:0] delay,
   input  logic [NCH-1:0]         coinc_mask,
   input  logic [NCH-1:0]         reset_cnt,
`ifdef NIM_GATE_EN
   input  logic                   gate_in,
   output logic [31:0]            gated_cnt,
`endif
   output logic [NCH-1:0]         trig_out,
   output logic                   coinc_out,
   output logic [NCH*CNT_W-1:0]   count,
   output logic [NCH*16-1:0]      holdoff_cnt
);

   localparam int DEPTH = 1 << DELAY_W;
   localparam logic [STR_W-1:0]   STR_ONE = STR_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
   localparam logic [DELAY_W-1:0] DLY_ONE = DELAY_W'(1);

   // A channel with an all-zero mask is disabled and never matches.
   function automatic logic pat_match(input logic [PAT_W-1:0] h,
                                      input logic [PAT_W-1:0] p,
                                      input logic [PAT_W-1:0] m);
      return (|m) & (&(~(h ^ p) | ~m));
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   function automatic logic [STR_W-1:0] dec_to_zero(input logic [STR_W-1:0] v);
      return (v == '0) ? v : v - STR_ONE;
   endfunction

   // Registered configuration copies
   logic [NCH-1:0]         invert_q;
   logic [NCH-1:0]         coinc_mask_q;
   logic [NCH*PAT_W-1:0]   mask_q;
   logic [NCH*PAT_W-1:0]   pattern_q;
   logic [NCH*STR_W-1:0]   stretch_q;
   logic [NCH*STR_W-1:0]   holdoff_q;
   logic [NCH*DELAY_W-1:0] delay_q;

   // Channel state
   logic [PAT_W-1:0] hist_q  [NCH];
   logic [PAT_W-1:0] hist_d  [NCH];
   logic [STR_W-1:0] hcnt_q  [NCH];
   logic [STR_W-1:0] hcnt_d  [NCH];
   logic [STR_W-1:0] scnt_q  [NCH];
   logic [STR_W-1:0] scnt_d  [NCH];
   logic [CNT_W-1:0] cnt_q   [NCH];
   logic [CNT_W-1:0] cnt_d   [NCH];
   logic [15:0]      hsup_q  [NCH];
   logic [15:0]      hsup_d  [NCH];
   logic [NCH-1:0]   match_q, match_d;
   logic [NCH-1:0]   pulse_q, pulse_d;
   logic [NCH-1:0]   trig_q, trig_d;
   logic             coinc_q, coinc_d;

   // Delay line: one ring per channel, sharing a single write pointer
   logic [NCH-1:0]     ring_q [DEPTH];
   logic [DELAY_W-1:0] wptr_q, wptr_d;
   logic [DELAY_W-1:0] rd_idx [NCH];

   logic [NCH-1:0] pol;
   logic [NCH-1:0] cand;
   logic [NCH-1:0] accept;
   logic [NCH-1:0] suppress;
   logic           gate_ok;

`ifdef NIM_GATE_EN
   logic           gate_q;
   logic [31:0]    gated_q, gated_d;
   logic [NCH-1:0] dropped;
`endif

   // Polarity, pattern match, edge detect and trigger accept/suppress decision
   always_comb begin
      pol      = trig_in ^ invert_q;
      match_d  = '0;
      cand     = '0;
      accept   = '0;
      suppress = '0;
`ifdef NIM_GATE_EN
      gate_ok  = gate_q;
      dropped  = '0;
`else
      gate_ok  = 1'b1;
`endif
      for (int i = 0; i < NCH; i++) begin
         match_d[i]  = pat_match(hist_q[i], pattern_q[i*PAT_W +: PAT_W],
                                 mask_q[i*PAT_W +: PAT_W]);
         cand[i]     = match_d[i] & ~match_q[i];
         accept[i]   = cand[i] & gate_ok & (hcnt_q[i] == '0);
         suppress[i] = cand[i] & gate_ok & (hcnt_q[i] != '0);
`ifdef NIM_GATE_EN
         dropped[i]  = cand[i] & ~gate_ok;
`endif
      end
   end

   // Next state for history, holdoff/stretch counters, pulse, delay tap and counters
   always_comb begin
      hist_d  = '{default: '0};
      hcnt_d  = '{default: '0};
      scnt_d  = '{default: '0};
      cnt_d   = '{default: '0};
      hsup_d  = '{default: '0};
      rd_idx  = '{default: '0};
      pulse_d = '0;
      trig_d  = '0;
      wptr_d  = wptr_q + DLY_ONE;
      coinc_d = (|coinc_mask_q) & (&(trig_q | ~coinc_mask_q));
      for (int i = 0; i < NCH; i++) begin
         hist_d[i] = {hist_q[i][PAT_W-2:0], pol[i]};
         // a suppressed candidate leaves the holdoff counter running down
         hcnt_d[i] = accept[i] ? holdoff_q[i*STR_W +: STR_W] : dec_to_zero(hcnt_q[i]);
         // an accepted trigger during an active stretch restarts it
         scnt_d[i] = accept[i] ? stretch_q[i*STR_W +: STR_W] : dec_to_zero(scnt_q[i]);
         // zero stretch length passes the polarity-corrected input straight through
         pulse_d[i] = (stretch_q[i*STR_W +: STR_W] == '0) ? pol[i] : (scnt_q[i] != '0);
         rd_idx[i]  = wptr_q - delay_q[i*DELAY_W +: DELAY_W];
         trig_d[i]  = (delay_q[i*DELAY_W +: DELAY_W] == '0) ? pulse_q[i]
                                                           : ring_q[rd_idx[i]][i];
         // counter clear wins over a simultaneous increment
         if (reset_cnt[i]) begin
            cnt_d[i]  = '0;
            hsup_d[i] = '0;
         end else begin
            cnt_d[i]  = accept[i]   ? sat_inc_cnt(cnt_q[i]) : cnt_q[i];
            hsup_d[i] = suppress[i] ? sat_inc16(hsup_q[i])  : hsup_q[i];
         end
      end
   end

`ifdef NIM_GATE_EN
   // Count candidates dropped by a closed gate; cleared together with channel 0
   always_comb begin
      gated_d = gated_q;
      for (int i = 0; i < NCH; i++) begin
         if (dropped[i]) begin
            gated_d = (&gated_d) ? gated_d : gated_d + 32'd1;
         end
      end
      if (reset_cnt[0]) begin
         gated_d = '0;
      end
   end
`endif

   // Configuration capture: all logic works from these copies
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         invert_q     <= '0;
         coinc_mask_q <= '0;
         mask_q       <= '0;
         pattern_q    <= '0;
         stretch_q    <= '0;
         holdoff_q    <= '0;
         delay_q      <= '0;
`ifdef NIM_GATE_EN
         gate_q       <= 1'b0;
`endif
      end else begin
         invert_q     <= invert;
         coinc_mask_q <= coinc_mask;
         mask_q       <= mask;
         pattern_q    <= trig_pattern;
         stretch_q    <= stretch;
         holdoff_q    <= holdoff;
         delay_q      <= delay;
`ifdef NIM_GATE_EN
         gate_q       <= gate_in;
`endif
      end
   end

   // Per-channel conditioning state and counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_q  <= '{default: '0};
         hcnt_q  <= '{default: '0};
         scnt_q  <= '{default: '0};
         cnt_q   <= '{default: '0};
         hsup_q  <= '{default: '0};
         match_q <= '0;
         pulse_q <= '0;
`ifdef NIM_GATE_EN
         gated_q <= '0;
`endif
      end else begin
         hist_q  <= hist_d;
         hcnt_q  <= hcnt_d;
         scnt_q  <= scnt_d;
         cnt_q   <= cnt_d;
         hsup_q  <= hsup_d;
         match_q <= match_d;
         pulse_q <= pulse_d;
`ifdef NIM_GATE_EN
         gated_q <= gated_d;
`endif
      end
   end

   // Delay-line rings and shared write pointer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            ring_q[k] <= '0;
         end
         wptr_q <= '0;
      end else begin
         ring_q[wptr_q] <= pulse_q;
         wptr_q         <= wptr_d;
      end
   end

   // Output registers: delayed triggers and coincidence one cycle behind them
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         trig_q  <= '0;
         coinc_q <= 1'b0;
      end else begin
         trig_q  <= trig_d;
         coinc_q <= coinc_d;
      end
   end

   // Pack per-channel counters onto the flat output buses
   always_comb begin
      count       = '0;
      holdoff_cnt = '0;
      for (int i = 0; i < NCH; i++) begin
         count[i*CNT_W +: CNT_W] = cnt_q[i];
         holdoff_cnt[i*16 +: 16] = hsup_q[i];
      end
   end

   assign trig_out  = trig_q;
   assign coinc_out = coinc_q;
`ifdef NIM_GATE_EN
   assign gated_cnt = gated_q;
`endif

endmodule

// File: tb/tb_nim_input_bank.sv
// Testbench for nim_input_bank: directed scenarios plus randomized traffic,
// all outputs compared each cycle against a time-history reference model.
module tb_nim_input_bank;

   localparam int NCH     = 4;
   localparam int PAT_W   = 8;
   localparam int DELAY_W = 7;
   localparam int STR_W   = 8;
   localparam int CNT_W   = 5;

   logic                   clk = 1'b0;
   logic                   reset_n;
   logic [NCH-1:0]         trig_in, invert, coinc_mask, reset_cnt;
   logic [NCH*PAT_W-1:0]   mask, trig_pattern;
   logic [NCH*STR_W-1:0]   stretch, holdoff;
   logic [NCH*DELAY_W-1:0] delay;
   logic [NCH-1:0]         trig_out;
   logic                   coinc_out;
   logic [NCH*CNT_W-1:0]   count;
   logic [NCH*16-1:0]      holdoff_cnt;
`ifdef NIM_GATE_EN
   logic                   gate_in;
   logic [31:0]            gated_cnt;
`endif

   int n_checks;
   int n_fail;

   nim_input_bank #(
      .NCH(NCH), .PAT_W(PAT_W), .DELAY_W(DELAY_W), .STR_W(STR_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .trig_in(trig_in), .invert(invert),
      .mask(mask), .trig_pattern(trig_pattern), .stretch(stretch),
      .holdoff(holdoff), .delay(delay), .coinc_mask(coinc_mask),
      .reset_cnt(reset_cnt),
`ifdef NIM_GATE_EN
      .gate_in(gate_in), .gated_cnt(gated_cnt),
`endif
      .trig_out(trig_out), .coinc_out(coinc_out), .count(count),
      .holdoff_cnt(holdoff_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Configuration as last captured, input history, counters, and a log of
   // the conditioned pulse indexed by cycle number since reset; the delayed
   // output is just that log read d+1 cycles back.
   bit [NCH-1:0]   m_inv, m_cm;
   bit [PAT_W-1:0] m_msk [NCH];
   bit [PAT_W-1:0] m_pat [NCH];
   bit [PAT_W-1:0] m_hist[NCH];
   int             m_str [NCH], m_hold[NCH], m_dly[NCH];
   int             m_hc  [NCH], m_sc  [NCH];
   bit             m_matchp[NCH];
   bit             m_plog[NCH][256];
   longint         m_cnt [NCH];
   longint         m_hs  [NCH];
   bit             m_trig[NCH];
   bit             m_coinc;
   int             m_t;
   bit             m_gate;
   longint         m_gc;

   task automatic model_reset();
      m_inv = '0; m_cm = '0; m_coinc = 0; m_t = 0; m_gate = 0; m_gc = 0;
      for (int c = 0; c < NCH; c++) begin
         m_msk[c] = '0; m_pat[c] = '0; m_hist[c] = '0;
         m_str[c] = 0; m_hold[c] = 0; m_dly[c] = 0; m_hc[c] = 0; m_sc[c] = 0;
         m_matchp[c] = 0; m_cnt[c] = 0; m_hs[c] = 0; m_trig[c] = 0;
         for (int k = 0; k < 256; k++) m_plog[c][k] = 0;
      end
   endtask

   // Advance the model by one clock, using the inputs currently driven.
   task automatic model_step();
      bit     ncoinc, pol, mt, cand, gok, acc, sup, npulse;
      bit     ntrig[NCH];
      int     n, src;
      longint cmax;
      cmax = (longint'(1) << CNT_W) - 1;
      n = m_t + 1;
      ncoinc = (m_cm != 0);
      for (int c = 0; c < NCH; c++) if (m_cm[c] && !m_trig[c]) ncoinc = 0;
      for (int c = 0; c < NCH; c++) begin
         pol = trig_in[c] ^ m_inv[c];
         mt = (m_msk[c] != 0);
         for (int b = 0; b < PAT_W; b++)
            if (m_msk[c][b] && (m_hist[c][b] != m_pat[c][b])) mt = 0;
         cand = mt && !m_matchp[c];
`ifdef NIM_GATE_EN
         gok = m_gate;
`else
         gok = 1;
`endif
         acc = cand && gok && (m_hc[c] == 0);
         sup = cand && gok && (m_hc[c] != 0);
         if (cand && !gok && m_gc < 64'hFFFF_FFFF) m_gc++;
         src = n - 1 - m_dly[c];
         ntrig[c] = (src >= 0) ? m_plog[c][src % 256] : 0;
         npulse = (m_str[c] == 0) ? pol : (m_sc[c] != 0);
         m_plog[c][n % 256] = npulse;
         m_sc[c] = acc ? m_str[c]  : (m_sc[c] > 0 ? m_sc[c] - 1 : 0);
         m_hc[c] = acc ? m_hold[c] : (m_hc[c] > 0 ? m_hc[c] - 1 : 0);
         if (reset_cnt[c]) begin
            m_cnt[c] = 0; m_hs[c] = 0;
         end else begin
            if (acc && m_cnt[c] < cmax) m_cnt[c]++;
            if (sup && m_hs[c] < 65535) m_hs[c]++;
         end
         m_hist[c] = {m_hist[c][PAT_W-2:0], pol};
         m_matchp[c] = mt;
      end
      if (reset_cnt[0]) m_gc = 0;
      for (int c = 0; c < NCH; c++) m_trig[c] = ntrig[c];
      m_coinc = ncoinc;
      // configuration capture
      m_inv = invert; m_cm = coinc_mask;
      for (int c = 0; c < NCH; c++) begin
         m_msk[c]  = mask[c*PAT_W +: PAT_W];
         m_pat[c]  = trig_pattern[c*PAT_W +: PAT_W];
         m_str[c]  = int'(stretch[c*STR_W +: STR_W]);
         m_hold[c] = int'(holdoff[c*STR_W +: STR_W]);
         m_dly[c]  = int'(delay[c*DELAY_W +: DELAY_W]);
      end
`ifdef NIM_GATE_EN
      m_gate = gate_in;
`endif
      m_t = n;
   endtask

   task automatic compare_all();
      for (int c = 0; c < NCH; c++) begin
         check($sformatf("trig_out[%0d]", c), 64'(trig_out[c]), 64'(m_trig[c]));
         check($sformatf("count[%0d]", c), 64'(count[c*CNT_W +: CNT_W]), m_cnt[c]);
         check($sformatf("holdoff_cnt[%0d]", c), 64'(holdoff_cnt[c*16 +: 16]), m_hs[c]);
      end
      check("coinc_out", 64'(coinc_out), 64'(m_coinc));
`ifdef NIM_GATE_EN
      check("gated_cnt", 64'(gated_cnt), m_gc);
`endif
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic set_ch(input int c, input bit inv, input logic [PAT_W-1:0] msk,
                         input logic [PAT_W-1:0] pat, input int str, input int hold,
                         input int dly);
      invert[c] = inv;
      mask[c*PAT_W +: PAT_W]         = msk;
      trig_pattern[c*PAT_W +: PAT_W] = pat;
      stretch[c*STR_W +: STR_W]      = STR_W'(str);
      holdoff[c*STR_W +: STR_W]      = STR_W'(hold);
      delay[c*DELAY_W +: DELAY_W]    = DELAY_W'(dly);
   endtask

   int hi_cnt, lat;
   bit found;

   initial begin
      n_checks = 0; n_fail = 0;
      reset_n = 1'b1;
      trig_in = '0; invert = '0; coinc_mask = '0; reset_cnt = '0;
      mask = '0; trig_pattern = '0; stretch = '0; holdoff = '0; delay = '0;
`ifdef NIM_GATE_EN
      gate_in = 1'b1;
`endif
      model_reset();
      #3 reset_n = 1'b0;
      #1 compare_all();
      repeat (2) begin @(posedge clk); #1; compare_all(); end
      reset_n = 1'b1;
      repeat (2) tick();

      // Reset in the middle of a stretched pulse
      set_ch(0, 0, 8'h01, 8'h01, 20, 0, 0);
      trig_in[0] = 1'b1;
      tick();
      trig_in[0] = 1'b0;
      repeat (4) tick();
      check("rst_pre_trig", 64'(trig_out[0]), 64'd1);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      check("rst_trig_out", 64'(trig_out), 64'd0);
      check("rst_count0", 64'(count[0 +: CNT_W]), 64'd0);
      compare_all();
      @(posedge clk); #1; compare_all();
      reset_n = 1'b1;
      set_ch(0, 0, 8'h01, 8'h01, 20, 0, 127);
      hi_cnt = 0;
      repeat (135) begin tick(); if (trig_out[0]) hi_cnt++; end
      check("rst_no_residue", 64'(hi_cnt), 64'd0);

      // Pattern match with edge detect: long input gives one trigger
      set_ch(1, 0, 8'h03, 8'h01, 8, 0, 0);
      tick();
      hi_cnt = 0;
      trig_in[1] = 1'b1;
      for (int k = 0; k < 25; k++) begin
         if (k == 10) trig_in[1] = 1'b0;
         tick();
         if (trig_out[1]) hi_cnt++;
      end
      check("pat_count1", 64'(count[1*CNT_W +: CNT_W]), 64'd1);
      check("pat_width", 64'(hi_cnt), 64'd8);

      // Holdoff: 6 pulses every 4 cycles with holdoff 10
      set_ch(2, 0, 8'h01, 8'h01, 2, 10, 0);
      tick();
      repeat (6) begin
         trig_in[2] = 1'b1; tick();
         trig_in[2] = 1'b0; repeat (3) tick();
      end
      repeat (10) tick();
      check("hold_count2", 64'(count[2*CNT_W +: CNT_W]), 64'd2);
      check("hold_supp2", 64'(holdoff_cnt[2*16 +: 16]), 64'd4);

      // Delay line latency at delay 0 and at the maximum delay
      for (int pass = 0; pass < 2; pass++) begin
         set_ch(3, 0, 8'h01, 8'h01, 1, 0, (pass == 0) ? 0 : 127);
         repeat (200) tick();
         found = 0; lat = 0;
         trig_in[3] = 1'b1;
         for (int k = 1; k <= 300 && !found; k++) begin
            tick();
            if (k == 1) trig_in[3] = 1'b0;
            if (trig_out[3]) begin found = 1; lat = k; end
         end
         check(pass == 0 ? "lat_delay0" : "lat_delay127", 64'(lat),
               pass == 0 ? 64'd4 : 64'd131);
      end
      repeat (5) tick();

      // Coincidence of channels 0 and 2 in passthrough
      for (int c = 0; c < NCH; c++) set_ch(c, 0, 8'h01, 8'h01, 0, 0, 0);
      coinc_mask = 4'b0101;
      repeat (3) tick();
      hi_cnt = 0;
      for (int k = 0; k < 14; k++) begin
         trig_in[0] = (k <= 4);
         trig_in[2] = (k >= 2 && k <= 6);
         tick();
         if (coinc_out) hi_cnt++;
      end
      check("coinc_width", 64'(hi_cnt), 64'd3);
      coinc_mask = '0;

      // Counter saturation, then clear racing a trigger
      reset_cnt[1] = 1'b1; tick(); reset_cnt[1] = 1'b0;
      repeat (35) begin
         trig_in[1] = 1'b1; tick();
         trig_in[1] = 1'b0; tick();
      end
      repeat (3) tick();
      check("sat_count1", 64'(count[1*CNT_W +: CNT_W]), 64'd31);
      trig_in[1] = 1'b1; tick();
      trig_in[1] = 1'b0; reset_cnt[1] = 1'b1; tick();
      reset_cnt[1] = 1'b0; tick();
      check("clr_wins", 64'(count[1*CNT_W +: CNT_W]), 64'd0);

`ifdef NIM_GATE_EN
      // Gate: 3 triggers while closed, 2 while open
      reset_cnt[0] = 1'b1; tick(); reset_cnt[0] = 1'b0;
      gate_in = 1'b0; tick();
      repeat (3) begin trig_in[0] = 1'b1; tick(); trig_in[0] = 1'b0; repeat (2) tick(); end
      gate_in = 1'b1; tick();
      repeat (2) begin trig_in[0] = 1'b1; tick(); trig_in[0] = 1'b0; repeat (2) tick(); end
      repeat (3) tick();
      check("gate_count0", 64'(count[0 +: CNT_W]), 64'd2);
      check("gate_dropped", 64'(gated_cnt), 64'd3);
`endif

      // Randomized traffic with randomized configuration
      for (int blk = 0; blk < 20; blk++) begin
         for (int c = 0; c < NCH; c++) begin
            logic [PAT_W-1:0] msk;
            case ($urandom_range(0, 3))
               0: msk = 8'h00;
               1: msk = 8'h01;
               2: msk = 8'h03;
               default: msk = PAT_W'($urandom);
            endcase
            set_ch(c, bit'($urandom_range(0, 1)), msk, PAT_W'($urandom),
                   int'($urandom_range(0, 12)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 127)));
         end
         coinc_mask = NCH'($urandom);
         for (int k = 0; k < 150; k++) begin
            trig_in = NCH'($urandom);
            for (int c = 0; c < NCH; c++) reset_cnt[c] = ($urandom_range(0, 31) == 0);
`ifdef NIM_GATE_EN
            gate_in = ($urandom_range(0, 3) != 0);
`endif
            tick();
         end
      end
      reset_cnt = '0;
      trig_in = '0;
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nim_input_bank.md
Name: nim_input_bank

Overview:
Multi-channel, parametrised NIM front-end conditioning bank. Each channel does the following:
- polarity select;
- masked pattern match on a shift-register history;
- rising-edge trigger generation with programmable holdoff;
- counter-based pulse stretch;
- programmable delay line.

Per-channel saturating trigger counters and an N-fold coincidence output are included. The bank sits between the NIM input buffers and the trigger logic/register bank.

Parameters:
NCH, 4, number of channels
PAT_W, 8, pattern/history shift-register width
DELAY_W, 7, delay select width; delay line depth 2**DELAY_W
STR_W, 8, stretch and holdoff counter width
CNT_W, 32, trigger counter width

Ports:
clk  in  1  single clock; all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
trig_in  in  NCH  raw NIM inputs, pre-synchronised, bit i = channel i
invert  in  NCH  per-channel polarity invert
mask  in  NCH*PAT_W  per-channel pattern bit enables, channel i at [i*PAT_W +: PAT_W]
trig_pattern  in  NCH*PAT_W  per-channel match pattern
stretch  in  NCH*STR_W  per-channel stretch length in cycles; 0 = passthrough
holdoff  in  NCH*STR_W  per-channel re-trigger holdoff in cycles
delay  in  NCH*DELAY_W  per-channel delay in cycles
coinc_mask  in  NCH  channels participating in coincidence
reset_cnt  in  NCH  per-channel counter clear
trig_out  out  NCH  conditioned, delayed outputs
coinc_out  out  1  coincidence of masked trig_out bits
count  out  NCH*CNT_W  per-channel accepted-trigger counters
holdoff_cnt  out  NCH*16  per-channel counts of triggers suppressed by holdoff (16-bit, saturating)

Behaviour:
- Reset (reset_n=0, async): all registers 0, including config copies, shift registers, counters, delay-line flops and outputs. trig_out=0, coinc_out=0, count=0, holdoff_cnt=0.
- Config inputs (invert, mask, trig_pattern, stretch, holdoff, delay, coinc_mask) registered once (cfg_z); all logic uses cfg_z. A change takes effect one cycle later.
- pol[i] = trig_in[i] ^ invert_z[i].
- Pattern history: hist[i] <= {hist[i][PAT_W-2:0], pol[i]}.
- Match: match[i] = &(~(hist ^ pattern_z) | ~mask_z), forced 0 when mask_z==0 (channel disabled).
- Edge detect: trigger candidate cand[i] = match[i] & ~match_q[i]. A continuous match yields one candidate.
- Holdoff:
  - hcnt[i]=0 and cand: trigger accepted, hcnt loaded with holdoff_z.
  - hcnt[i]!=0: hcnt decrements. A cand in this state is suppressed, holdoff_cnt increments (saturates at 0xFFFF), hcnt is not reloaded.
  - holdoff_z=0: no holdoff.
- Stretch:
  - stretch_z=0: pulse[i]=pol[i] (raw passthrough; accepted triggers still counted).
  - stretch_z!=0: scnt loaded with stretch_z on accepted trigger, else decremented when nonzero; pulse[i] = (scnt!=0).
  - An accepted trigger during an active stretch reloads scnt (retrigger extends).
- Delay:
  - Per-channel ring of 2**DELAY_W flops, shared write pointer wptr incrementing every cycle, wrapping modulo 2**DELAY_W.
  - ring[wptr] <= pulse.
  - trig_out <= (delay_z==0) ? pulse : ring[wptr - delay_z] (modulo).
  - Latency pulse -> trig_out = delay_z+1 cycles; max 2**DELAY_W.
  - Changing delay_z mid-stream may drop or duplicate up to delay-difference cycles of history; no other side effect.
- Coincidence:
  - coinc_out <= (coinc_mask_z!=0) & &(trig_out | ~coinc_mask_z).
  - One cycle after trig_out.
- Counters:
  - count[i] increments on accepted trigger and saturates at 2**CNT_W-1.
  - reset_cnt[i] clears both count[i] and holdoff_cnt[i] and wins over a simultaneous increment.
- Latency trig_in -> trig_out, stretch_z!=0, mask covering hist[0] only, delay 0: 4 cycles.
  - cycle 1: hist;
  - cycle 2: match_q/trigger accept into scnt;
  - cycle 3: pulse;
  - cycle 4: trig_out.
- Latency in passthrough mode (stretch_z=0): 2 cycles from trig_in (cfg path excluded).

Optional Feature:
NIM_GATE_EN. When defined:
- Extra port gate_in (in, 1), with registered copy gate_z.
- Triggers are accepted only when gate_z=1.
- Candidates with gate_z=0 are dropped: not counted, no holdoff or stretch load.
- They increment a 32-bit saturating output gated_cnt, cleared by reset_cnt[0].

When undefined: no gate_in or gated_cnt ports, and all candidates go to holdoff logic.

Test Plan:
- Reset mid-stretch: ch0 stretch=20, trigger, assert reset_n=0 at cycle 5 -> trig_out, count, and all ring flops 0 immediately; no residual pulse after release.
- Pattern/edge: ch1 mask=0x03, pattern=0x01, invert=0, trig_in high 10 cycles -> exactly one trigger, count=1, trig_out high 8 cycles with stretch=8 and delay=0.
- Holdoff: ch2 holdoff=10, input pulses every 4 cycles, 6 pulses -> count=2, holdoff_cnt=4.
- Delay wrap: ch3 delay=127, stretch=1 -> trig_out asserted exactly 128 cycles after pulse; delay=0 -> 1 cycle.
- Coincidence/counters: coinc_mask=0x5, ch0 and ch2 overlap 3 cycles -> coinc_out high 3 cycles. Count preloaded to 2**CNT_W-1 saturates; reset_cnt with simultaneous trigger -> count 0.
- NIM_GATE_EN: gate low during 3 triggers, high during 2 -> count=2, gated_cnt=3.
